ev19_button_irq_ctrl: RTL and testbench
=======================================

// Module: ev19_button_irq_ctrl
// PURPOSE
//  Avalon-MM slave controlling the SoC push-button inputs: synchronises, debounces,
//  captures edges and raises a maskable interrupt to the EV19 core. Sits between the
//  board button pins and the interconnect. Extends the plain push-button input port
//  with a run-time debounce threshold, an edge-capture register and an IRQ mask.
// PARAMETERS
//  WIDTH            1      number of button inputs (1..32)
//  CNT_W            20     debounce counter / threshold width (1..32)
//  DEFAULT_DEBOUNCE 50000  threshold loaded at reset (1 ms at 50 MHz); must fit CNT_W
// PORTS
//  clk        in   1      system clock; the only clock
//  reset_n    in   1      asynchronous active-low reset
//  address    in   2      Avalon word address
//  chipselect in   1      Avalon slave select
//  write_n    in   1      Avalon write strobe, active low
//  writedata  in   32     Avalon write data
//  readdata   out  32     Avalon read data, registered
//  in_port    in   WIDTH  raw asynchronous button pins
//  irq        out  1      level interrupt, registered
// BEHAVIOUR
//  Reset: sync flops, stable, edge, mask, counters, readdata and irq = 0;
//   threshold = DEFAULT_DEBOUNCE.
//  Register map (write = chipselect & !write_n; bits above WIDTH/CNT_W read 0, writes ignored):
//   0 DATA    RO   debounced level stable[WIDTH-1:0]; writes ignored
//   1 DEBOUNCE RW  threshold[CNT_W-1:0]
//   2 MASK    RW   irq mask[WIDTH-1:0]
//   3 EDGE    RW1C edge capture[WIDTH-1:0]; writing 1 clears the bit, writing 0 has no effect
//  Read: readdata <= mux(address) every clk, independent of chipselect; 1-cycle latency.
//  Sync: 2-flop synchroniser per bit (sync), 2 cycles from in_port to sync.
//  Debounce, per bit:
//   - sync == stable: counter <= 0.
//   - sync != stable and counter >= threshold: stable <= sync, counter <= 0.
//   - otherwise counter <= counter + 1 (saturates at all-ones, no wrap).
//   - Threshold N: stable follows a steady change N+1 cycles after sync changes.
//     N = 0 gives 1 cycle.
//   - A glitch shorter than N+1 cycles never reaches stable.
//   - A threshold write takes effect next cycle. If the counter already exceeds the
//     new value, stable updates on the next differing cycle (>= compare).
//  Edge: stable_d <= stable; rise = stable & ~stable_d.
//   - edge[i] set on rise[i]. Set and W1C in the same cycle: set wins.
//   - Pins held high through reset produce one rising edge after debounce (intended).
//  IRQ: irq <= |(edge & mask), 1 cycle after edge/mask update. Cleared 1 cycle after
//   the last masked edge bit is cleared.
//  reset_n low mid-debounce: all state returns to reset values immediately.
// CONFIGURATION
//  EV19_BTN_BOTH_EDGES_EN defined: edge capture also sets on falling edges
//   (stable ^ stable_d).
//  Not defined: rising edges only. The register map is identical in both builds.
// TESTING
//  1 Reset: reset_n=0 -> readdata=0, irq=0. After release, read addr1 -> 50000.
//  2 Debounce: threshold=4, WIDTH=1; in_port 0->1 held -> DATA bit0=1 exactly 2+5
//    cycles later. A 3-cycle pulse -> DATA stays 0 and EDGE stays 0.
//  3 IRQ: mask=1, threshold=0, press -> EDGE=1 and irq=1 one cycle after EDGE.
//    Write addr3=1 -> EDGE=0, irq=0 the next cycle.
//  4 Set/clear collision: W1C of bit0 in the same cycle as a rise -> EDGE bit0 stays 1.
//  5 Mask: mask=0, press -> EDGE=1, irq=0. Write mask=1 -> irq=1 one cycle later.
//  6 Both-edges: with EV19_BTN_BOTH_EDGES_EN, a release sets EDGE.
//    Without the macro, a release leaves EDGE=0.

Source files
------------

// File: rtl/ev19_button_irq_ctrl.sv
// ---------------------------------------------------------------------------
// ev19_button_irq_ctrl
//
// Avalon-MM slave for the SoC push-button inputs. Each raw pin is brought
// into the clock domain with a two-flop synchroniser. It is then debounced
// against a run-time threshold. Edges of the debounced level are captured in
// a write-one-to-clear register, and a maskable level interrupt is raised to
// the EV19 core.
//
// Build option:
//   EV19_BTN_BOTH_EDGES_EN  when defined, edge capture also sets on falling
//                           edges of the debounced level. When undefined,
//                           only rising edges are captured. The register map
//                           is the same in both builds.
//
// Register map (word addresses; unused upper bits read 0):
//   0 DATA      RO    debounced level
//   1 DEBOUNCE  RW    debounce threshold
//   2 MASK      RW    interrupt mask
//   3 EDGE      RW1C  edge capture
//
// Ports:
//   clk         in   1      system clock
//   reset_n     in   1      asynchronous active-low reset
//   address     in   2      Avalon word address
//   chipselect  in   1      Avalon slave select
//   write_n     in   1      Avalon write strobe, active low
//   writedata   in   32     Avalon write data
//   readdata    out  32     registered read data, one-cycle latency
//   in_port     in   WIDTH  raw asynchronous button pins
//   irq         out  1      registered level interrupt
// ---------------------------------------------------------------------------
module ev19_button_irq_ctrl #(
    parameter int WIDTH            = 1,
    parameter int CNT_W            = 20,
    parameter int DEFAULT_DEBOUNCE = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [CNT_W-1:0] THR_RESET = CNT_W'(DEFAULT_DEBOUNCE);
    localparam logic [1:0]       ADDR_DATA = 2'd0;
    localparam logic [1:0]       ADDR_THR  = 2'd1;
    localparam logic [1:0]       ADDR_MASK = 2'd2;
    localparam logic [1:0]       ADDR_EDGE = 2'd3;

    // Counter increment that sticks at all-ones instead of wrapping. A wrap
    // would let a long-differing input look "fresh" again.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync_meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] stable_q,     stable_d;
    logic [WIDTH-1:0] stable_dly_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [CNT_W-1:0] thr_q,        thr_d;
    logic [WIDTH-1:0] mask_q,       mask_d;
    logic [WIDTH-1:0] edge_q,       edge_d;
    logic [31:0]      readdata_q,   readdata_d;
    logic             irq_q,        irq_d;

    logic             wr_s;
    logic [WIDTH-1:0] edge_evt_s;
    logic             unused_wdata_s;

    assign wr_s = chipselect & ~write_n;

    // Write-data bits above WIDTH/CNT_W are deliberately ignored.
    assign unused_wdata_s = ^writedata;

    // ------------------------------------------------------------------
    // Debounced-level event selection
    // ------------------------------------------------------------------
`ifdef EV19_BTN_BOTH_EDGES_EN
    assign edge_evt_s = stable_q ^ stable_dly_q;
`else
    assign edge_evt_s = stable_q & ~stable_dly_q;
`endif

    // Two-flop synchroniser for the raw pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta_q <= {WIDTH{1'b0}};
            sync_q      <= {WIDTH{1'b0}};
        end else begin
            sync_meta_q <= in_port;
            sync_q      <= sync_meta_q;
        end
    end

    // Per-bit debounce: count cycles where sync differs from stable, accept once
    // the count has reached the threshold. The >= compare lets a lowered
    // threshold take effect on the next differing cycle.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_q[i] == stable_q[i]) begin
                cnt_d[i] = {CNT_W{1'b0}};
            end else if (cnt_q[i] >= thr_q) begin
                stable_d[i] = sync_q[i];
                cnt_d[i]    = {CNT_W{1'b0}};
            end else begin
                cnt_d[i] = sat_inc(cnt_q[i]);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q     <= {WIDTH{1'b0}};
            stable_dly_q <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    // Threshold and mask next-state from bus writes.
    always_comb begin
        thr_d  = thr_q;
        mask_d = mask_q;
        if (wr_s && (address == ADDR_THR)) begin
            thr_d = writedata[CNT_W-1:0];
        end else begin
            thr_d = thr_q;
        end
        if (wr_s && (address == ADDR_MASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end else begin
            mask_d = mask_q;
        end
    end

    // Edge capture: W1C clear first, then OR in new events so a capture in the
    // same cycle as a clear of that bit survives.
    always_comb begin
        edge_d = edge_q;
        if (wr_s && (address == ADDR_EDGE)) begin
            edge_d = edge_q & ~writedata[WIDTH-1:0];
        end else begin
            edge_d = edge_q;
        end
        edge_d = edge_d | edge_evt_s;
    end

    // Interrupt is the OR of the masked captured edges, registered once more.
    always_comb begin
        irq_d = |(edge_q & mask_q);
    end

    // Read mux, sampled every cycle regardless of chipselect.
    always_comb begin
        readdata_d = 32'd0;
        case (address)
            ADDR_DATA: readdata_d[WIDTH-1:0] = stable_q;
            ADDR_THR:  readdata_d[CNT_W-1:0] = thr_q;
            ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
            ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
            default:   readdata_d            = 32'd0;
        endcase
    end

    // Control/status registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thr_q      <= THR_RESET;
            mask_q     <= {WIDTH{1'b0}};
            edge_q     <= {WIDTH{1'b0}};
            readdata_q <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            thr_q      <= thr_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_ev19_button_irq_ctrl.sv
module tb_ev19_button_irq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [1:0]   address = 2'd0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = 32'd0;
    logic [31:0]  readdata;
    logic [W-1:0] in_port = '0;
    logic         irq;

    int checks = 0;
    int errors = 0;

    ev19_button_irq_ctrl #(.WIDTH(W), .CNT_W(20), .DEFAULT_DEBOUNCE(50000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [W-1:0] m_pin_hist [2];   // [0] newest sample, [1] synchronised value
    logic [W-1:0] m_stable, m_prev, m_edge, m_mask, n_stable, n_edge, evt;
    logic [19:0]  m_thr;
    int           m_run [W];        // consecutive cycles the pin disagreed with the level
    logic [31:0]  m_rdata, n_rdata;
    logic         m_irq, m_wr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pin_hist[0] = '0; m_pin_hist[1] = '0;
            m_stable = '0; m_prev = '0; m_edge = '0; m_mask = '0;
            m_thr = 20'd50000; m_rdata = 32'd0; m_irq = 1'b0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            m_wr = chipselect && !write_n;
            case (address)
                2'd0:    n_rdata = {28'd0, m_stable};
                2'd1:    n_rdata = {12'd0, m_thr};
                2'd2:    n_rdata = {28'd0, m_mask};
                default: n_rdata = {28'd0, m_edge};
            endcase
            m_irq = |(m_edge & m_mask);
`ifdef EV19_BTN_BOTH_EDGES_EN
            evt = m_stable ^ m_prev;
`else
            evt = m_stable & ~m_prev;
`endif
            n_edge = m_edge;
            if (m_wr && address == 2'd3) n_edge = n_edge & ~writedata[W-1:0];
            n_edge = n_edge | evt;
            // a level is accepted once it has disagreed for thr+1 cycles in a row
            n_stable = m_stable;
            for (int i = 0; i < W; i++) begin
                if (m_pin_hist[1][i] != m_stable[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] > int'(m_thr)) begin
                        n_stable[i] = m_pin_hist[1][i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_prev   = m_stable;
            m_stable = n_stable;
            m_edge   = n_edge;
            m_rdata  = n_rdata;
            if (m_wr && address == 2'd1) m_thr  = writedata[19:0];
            if (m_wr && address == 2'd2) m_mask = writedata[W-1:0];
            m_pin_hist[1] = m_pin_hist[0];
            m_pin_hist[0] = in_port;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (readdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want %h", readdata, 32'd0); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        @(negedge clk);
        ticks(2);
        reset_n = 1'b1;
        address = 2'd1;
        tick();
        checks++;
        if (readdata !== 32'd50000) begin errors++; $display("FAIL reset_thr: got %0d want 50000", readdata); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_after: got %b want 0", irq); end
    endtask

    task automatic test_debounce();
        bus_write(2'd1, 32'd4);
        address = 2'd0;
        ticks(4);
        in_port[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (readdata !== m_rdata) begin errors++; $display("FAIL deb_model c%0d: got %h want %h", k, readdata, m_rdata); end
            if (k == 7) begin
                checks++;
                if (readdata[0] !== 1'b0) begin errors++; $display("FAIL deb_early: got %b want 0", readdata[0]); end
            end
            if (k == 8) begin
                checks++;
                if (readdata[0] !== 1'b1) begin errors++; $display("FAIL deb_settle: got %b want 1", readdata[0]); end
            end
        end
        in_port[0] = 1'b0;
        ticks(10);
        bus_write(2'd3, 32'hF);
        address = 2'd0;
        ticks(2);
        in_port[0] = 1'b1;
        ticks(3);
        in_port[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (readdata[0] !== 1'b0) begin errors++; $display("FAIL glitch_data c%0d: got %b want 0", k, readdata[0]); end
        end
        address = 2'd3;
        tick();
        checks++;
        if (readdata[0] !== 1'b0) begin errors++; $display("FAIL glitch_edge: got %b want 0", readdata[0]); end
    endtask

    task automatic test_irq();
        bus_write(2'd2, 32'd1);
        bus_write(2'd1, 32'd0);
        bus_write(2'd3, 32'hF);
        address = 2'd3;
        ticks(2);
        in_port[0] = 1'b1;
        ticks(4);
        checks++;
        if (irq !== 1'b0 || readdata[0] !== 1'b0) begin errors++; $display("FAIL irq_early: got irq=%b edge=%b want 0/0", irq, readdata[0]); end
        tick();
        checks++;
        if (irq !== 1'b1 || readdata[0] !== 1'b1) begin errors++; $display("FAIL irq_set: got irq=%b edge=%b want 1/1", irq, readdata[0]); end
        bus_write(2'd3, 32'd1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b want 1", irq); end
        tick();
        checks++;
        if (irq !== 1'b0 || readdata[0] !== 1'b0) begin errors++; $display("FAIL irq_clear: got irq=%b edge=%b want 0/0", irq, readdata[0]); end
    endtask

    task automatic test_collision();
        in_port[0] = 1'b0;
        ticks(6);
        bus_write(2'd3, 32'hF);
        ticks(2);
        in_port[0] = 1'b1;
        ticks(3);
        bus_write(2'd3, 32'd1);   // lands on the cycle the rise is captured
        address = 2'd3;
        tick();
        checks++;
        if (readdata[0] !== 1'b1) begin errors++; $display("FAIL collision: got %b want 1", readdata[0]); end
        checks++;
        if (readdata !== m_rdata) begin errors++; $display("FAIL collision_model: got %h want %h", readdata, m_rdata); end
    endtask

    task automatic test_mask();
        bus_write(2'd2, 32'd0);
        in_port[0] = 1'b0;
        ticks(6);
        bus_write(2'd3, 32'hF);
        ticks(2);
        in_port[0] = 1'b1;
        address = 2'd3;
        ticks(8);
        checks++;
        if (readdata[0] !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL mask_off: got edge=%b irq=%b want 1/0", readdata[0], irq); end
        bus_write(2'd2, 32'd1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL mask_lat: got %b want 0", irq); end
        tick();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL mask_on: got %b want 1", irq); end
    endtask

    task automatic test_both_edges();
        logic exp_bit;
`ifdef EV19_BTN_BOTH_EDGES_EN
        exp_bit = 1'b1;
`else
        exp_bit = 1'b0;
`endif
        bus_write(2'd3, 32'hF);
        ticks(2);
        in_port[0] = 1'b0;
        address = 2'd3;
        ticks(8);
        checks++;
        if (readdata[0] !== exp_bit) begin errors++; $display("FAIL release_edge: got %b want %b", readdata[0], exp_bit); end
        checks++;
        if (irq !== exp_bit) begin errors++; $display("FAIL release_irq: got %b want %b", irq, exp_bit); end
    endtask

    task automatic test_async_reset();
        bus_write(2'd1, 32'd10);
        bus_write(2'd2, 32'hF);
        address = 2'd1;
        in_port[1] = 1'b1;
        ticks(5);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin errors++; $display("FAIL mid_reset: got rd=%h irq=%b want 0/0", readdata, irq); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checks++;
        if (readdata !== 32'd50000) begin errors++; $display("FAIL mid_reset_thr: got %0d want 50000", readdata); end
    endtask

    task automatic test_random();
        int op;
        bus_write(2'd1, {12'hABC, 20'd3});
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) in_port[$urandom_range(0, W - 1)] ^= 1'b1;
            op = $urandom_range(0, 9);
            address = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n = 1'b1;
            if (op == 0) begin
                chipselect = 1'b1; write_n = 1'b0;
                writedata = (address == 2'd1) ? {12'($urandom), 20'($urandom_range(0, 6))} : $urandom;
            end
            tick();
            checks++;
            if (readdata !== m_rdata) begin errors++; $display("FAIL rand_rdata c%0d: got %h want %h", c, readdata, m_rdata); end
            checks++;
            if (irq !== m_irq) begin errors++; $display("FAIL rand_irq c%0d: got %b want %b", c, irq, m_irq); end
        end
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_irq();
        test_collision();
        test_mask();
        test_both_edges();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
